// File: rtl/word_entry_ctrl.sv
// word_entry_ctrl: sequences writes into the letter register bank from decoded
// keyboard ASCII codes. It clears the bank on start, appends printable keys,
// erases on backspace and finishes the word on TAB.
// Optional build macro: WORD_ENTRY_CASE_FOLD_EN (fold a..z to A..Z before writing).
module word_entry_ctrl #(
  parameter int unsigned MAX_LEN   = 10,
  parameter logic [7:0]  FILL_CHAR = 8'h20,
  parameter logic [7:0]  TERM_CODE = 8'h09,
  parameter logic [7:0]  BS_CODE   = 8'h08
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       load,
  output logic [3:0] counter,
  output logic [7:0] ascii_code,
  output logic [3:0] length,
  output logic       busy,
  output logic       full,
  output logic       done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_ENTRY = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] LP_MAX  = 4'(MAX_LEN);
  localparam logic [3:0] LP_LAST = 4'(MAX_LEN - 1);

  logic [1:0] r_state, w_state_d;
  logic       r_load, w_load_d;
  logic [3:0] r_counter, w_counter_d;
  logic [7:0] r_ascii, w_ascii_d;
  logic [3:0] r_length, w_length_d;

  logic       w_is_print;
  logic [7:0] w_write_code;

  assign w_is_print = (key_code >= 8'h21) && (key_code <= 8'h7E);

`ifdef WORD_ENTRY_CASE_FOLD_EN
  // Lower-case letters are stored as upper case so compare logic sees one form.
  always_comb begin
    w_write_code = key_code;
    if ((key_code >= 8'h61) && (key_code <= 8'h7A)) begin
      w_write_code = key_code - 8'h20;
    end
  end
`else
  // Codes are written unchanged.
  always_comb begin
    w_write_code = key_code;
  end
`endif

  // Next-state and next-output decode; all outputs leave through registers.
  always_comb begin
    w_state_d   = r_state;
    w_load_d    = 1'b0;
    w_counter_d = r_counter;
    w_ascii_d   = r_ascii;
    w_length_d  = r_length;

    if (start) begin
      // start wins in every state: (re)begin the clear sweep at index 0.
      w_state_d   = S_CLEAR;
      w_load_d    = 1'b1;
      w_counter_d = 4'd0;
      w_ascii_d   = FILL_CHAR;
      w_length_d  = 4'd0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_counter == LP_LAST) begin
            w_state_d  = S_ENTRY;
            w_length_d = 4'd0;
          end else begin
            w_load_d    = 1'b1;
            w_counter_d = r_counter + 4'd1;
            w_ascii_d   = FILL_CHAR;
          end
        end
        S_ENTRY: begin
          if (key_valid) begin
            if (w_is_print) begin
              if (r_length < LP_MAX) begin
                w_load_d    = 1'b1;
                w_counter_d = r_length;
                w_ascii_d   = w_write_code;
                w_length_d  = r_length + 4'd1;
              end
            end else if (key_code == BS_CODE) begin
              if (r_length != 4'd0) begin
                w_load_d    = 1'b1;
                w_counter_d = r_length - 4'd1;
                w_ascii_d   = FILL_CHAR;
                w_length_d  = r_length - 4'd1;
              end
            end else if (key_code == TERM_CODE) begin
              if (r_length != 4'd0) begin
                w_state_d = S_DONE;
              end
            end
          end
        end
        default: begin
          // IDLE and DONE ignore keys and wait for start.
        end
      endcase
    end
  end

  // State and output registers; reset leaves the letter bank untouched.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_load    <= 1'b0;
      r_counter <= 4'd0;
      r_ascii   <= 8'h00;
      r_length  <= 4'd0;
    end else begin
      r_state   <= w_state_d;
      r_load    <= w_load_d;
      r_counter <= w_counter_d;
      r_ascii   <= w_ascii_d;
      r_length  <= w_length_d;
    end
  end

  assign load       = r_load;
  assign counter    = r_counter;
  assign ascii_code = r_ascii;
  assign length     = r_length;
  assign busy       = (r_state == S_CLEAR) || (r_state == S_ENTRY);
  assign full       = (r_length == LP_MAX);
  assign done       = (r_state == S_DONE);

endmodule
